// File: rtl/alu_exec_seq_if.sv
// rtl/alu_exec_seq_if.sv - instruction, load, ALU and debug bus for alu_exec_seq
//
// Purpose: bundles every non-clock/reset signal of the execute-stage sequencer.
// Signal names keep their direction suffix as seen from the sequencer.
//   slave  modport : the sequencer (alu_exec_seq) side
//   master modport : upstream issue logic / ALU / debug side
// Signals:
//   instr_valid_i/instr_ready_o   instruction handshake
//   op_i, rs1_i, rs2_i, rd_i      instruction fields
//   ld_i, ld_addr_i, ld_data_i    direct register-file write
//   alu_a_o, alu_b_o, alu_op_o    operands and function code to the ALU
//   alu_flags_o                   architectural flags to the ALU
//   alu_y_i, alu_flags_i          ALU result and flags
//   done_o                        write-back pulse
//   result_o                      last captured ALU result
//   dbg_addr_i, dbg_data_o        combinational register-file peek
interface alu_exec_seq_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int FLAG_SIZE      = 4,
  parameter int OP_WIDTH       = 4
) ();
  logic                      instr_valid_i;
  logic                      instr_ready_o;
  logic [OP_WIDTH-1:0]       op_i;
  logic [REG_ADDR_WIDTH-1:0] rs1_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_i;
  logic [REG_ADDR_WIDTH-1:0] rd_i;
  logic                      ld_i;
  logic [REG_ADDR_WIDTH-1:0] ld_addr_i;
  logic [DATA_WIDTH-1:0]     ld_data_i;
  logic [DATA_WIDTH-1:0]     alu_a_o;
  logic [DATA_WIDTH-1:0]     alu_b_o;
  logic [OP_WIDTH-1:0]       alu_op_o;
  logic [FLAG_SIZE-1:0]      alu_flags_o;
  logic [DATA_WIDTH-1:0]     alu_y_i;
  logic [FLAG_SIZE-1:0]      alu_flags_i;
  logic                      done_o;
  logic [DATA_WIDTH-1:0]     result_o;
  logic [REG_ADDR_WIDTH-1:0] dbg_addr_i;
  logic [DATA_WIDTH-1:0]     dbg_data_o;

  modport slave (
    input  instr_valid_i, op_i, rs1_i, rs2_i, rd_i,
    input  ld_i, ld_addr_i, ld_data_i,
    input  alu_y_i, alu_flags_i, dbg_addr_i,
    output instr_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_flags_o,
    output done_o, result_o, dbg_data_o
  );

  modport master (
    output instr_valid_i, op_i, rs1_i, rs2_i, rd_i,
    output ld_i, ld_addr_i, ld_data_i,
    output alu_y_i, alu_flags_i, dbg_addr_i,
    input  instr_ready_o, alu_a_o, alu_b_o, alu_op_o, alu_flags_o,
    input  done_o, result_o, dbg_data_o
  );
endinterface

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - execute-stage sequencer feeding a combinational ALU
//
// Purpose: accepts one ALU instruction per handshake, reads rs1 and rs2 from an
// internal 8x16 register file on consecutive cycles, presents the operands to
// the ALU for one cycle, captures result and flags, and writes the result to rd.
// One instruction every five cycles: IDLE -> READ_A -> READ_B -> EXEC -> WB.
// Ports:
//   clk_i    system clock, all state on the rising edge
//   reset_i  synchronous active-high reset, clears all state and registers
//   bus      alu_exec_seq_if.slave (handshake, load, ALU, debug signals)
module alu_exec_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int FLAG_SIZE      = 4,
  parameter int OP_WIDTH       = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  alu_exec_seq_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     rf [NUM_REGS];

  // Instruction fields latched at the handshake.
  logic [OP_WIDTH-1:0]       op_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  // Operand A is staged internally so that the ALU-facing registers only
  // change on entry to EXEC and otherwise hold their last values.
  logic [DATA_WIDTH-1:0]     op_a_q;
  logic [DATA_WIDTH-1:0]     alu_a_q;
  logic [DATA_WIDTH-1:0]     alu_b_q;
  logic [OP_WIDTH-1:0]       alu_op_q;

  logic [DATA_WIDTH-1:0]     result_q;
  logic [FLAG_SIZE-1:0]      flags_q;

  // A pending load steals the IDLE cycle, so ready drops whenever ld_i is high.
  assign bus.instr_ready_o = (state == IDLE) && !bus.ld_i && !reset_i;
  assign bus.done_o        = (state == WB);
  assign bus.alu_a_o       = alu_a_q;
  assign bus.alu_b_o       = alu_b_q;
  assign bus.alu_op_o      = alu_op_q;
  assign bus.alu_flags_o   = flags_q;
  assign bus.result_o      = result_q;
  assign bus.dbg_data_o    = rf[bus.dbg_addr_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rf       <= '{default: '0};
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      op_a_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_i) begin
            rf[bus.ld_addr_i] <= bus.ld_data_i;
          end else if (bus.instr_valid_i) begin
            op_q  <= bus.op_i;
            rs1_q <= bus.rs1_i;
            rs2_q <= bus.rs2_i;
            rd_q  <= bus.rd_i;
            state <= READ_A;
          end
        end
        READ_A: begin
          op_a_q <= rf[rs1_q];
          state  <= READ_B;
        end
        READ_B: begin
          alu_a_q  <= op_a_q;
          alu_b_q  <= rf[rs2_q];
          alu_op_q <= op_q;
          state    <= EXEC;
        end
        EXEC: begin
          result_q <= bus.alu_y_i;
          flags_q  <= bus.alu_flags_i;
          state    <= WB;
        end
        WB: begin
          // Reads of this instruction already happened, so rs==rd is safe.
          rf[rd_q] <= result_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
